// File: rtl/pong_pkg.sv
// Shared encodings and default geometry for the Pong game core.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam logic [1:0] KEY_UP   = 2'b10;
    localparam logic [1:0] KEY_DOWN = 2'b01;

    localparam logic DIR_RIGHT = 1'b1;
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;
    localparam logic DIR_UP    = 1'b0;

    localparam int DEF_SCREEN_W   = 640;
    localparam int DEF_SCREEN_H   = 480;
    localparam int DEF_PAD_H      = 64;
    localparam int DEF_PAD_W      = 8;
    localparam int DEF_PAD_DIST   = 16;
    localparam int DEF_BALL_SIZE  = 8;
    localparam int DEF_TICK_DIV   = 18;
    localparam int DEF_PAD_STEP   = 2;
    localparam int DEF_SPEED_MAX  = 3;
    localparam int DEF_SERVE_DLY  = 60;
    localparam int DEF_MAX_SCORE  = 9;

endpackage

// File: rtl/pong_tick_gen.sv
// Free-running game-tick divider: one-clock pulse every 2^TICK_DIV clocks.
module pong_tick_gen #(
    parameter int TICK_DIV = 18
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);

    logic [TICK_DIV-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_cnt <= '0;
        else       r_cnt <= r_cnt + 1'b1;
    end

    assign o_tick = &r_cnt;

endmodule

// File: rtl/pong_engine.sv
// Pong game core: paddles, ball motion, collisions, scoring and match sequencing.
module pong_engine
    import pong_pkg::*;
#(
    parameter int SCREEN_W    = DEF_SCREEN_W,
    parameter int SCREEN_H    = DEF_SCREEN_H,
    parameter int PAD_H       = DEF_PAD_H,
    parameter int PAD_W       = DEF_PAD_W,
    parameter int PAD_DIST    = DEF_PAD_DIST,
    parameter int BALL_SIZE   = DEF_BALL_SIZE,
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int PAD_STEP    = DEF_PAD_STEP,
    parameter int SPEED_MAX   = DEF_SPEED_MAX,
    parameter int SERVE_DELAY = DEF_SERVE_DLY,
    parameter int MAX_SCORE   = DEF_MAX_SCORE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] keys_left,
    input  logic [1:0] keys_right,
    input  logic       start,
    output logic [9:0] pad_left,
    output logic [9:0] pad_right,
    output logic [9:0] ball_x,
    output logic [8:0] ball_y,
    output logic [3:0] score_left,
    output logic [3:0] score_right,
    output logic [1:0] state,
    output logic       winner,
    output logic       frame_tick
);

    localparam int SPD_W = $clog2(SPEED_MAX + 1);
    localparam int SRV_W = $clog2(SERVE_DELAY + 1);

    localparam logic signed [10:0] C_PAD_MAX = 11'(SCREEN_H - PAD_H);
    localparam logic signed [10:0] C_STEP    = 11'(PAD_STEP);
    localparam logic signed [10:0] C_PAD_H   = 11'(PAD_H);
    localparam logic signed [10:0] C_BALL    = 11'(BALL_SIZE);
    localparam logic signed [10:0] C_LF      = 11'(PAD_DIST + PAD_W);
    localparam logic signed [10:0] C_RF      = 11'(SCREEN_W - PAD_DIST - PAD_W - BALL_SIZE);
    localparam logic signed [10:0] C_BX_MAX  = 11'(SCREEN_W - BALL_SIZE);
    localparam logic signed [10:0] C_BY_MAX  = 11'(SCREEN_H - BALL_SIZE);

    localparam logic [9:0] PAD_INIT = 10'((SCREEN_H - PAD_H) / 2);
    localparam logic [9:0] BX_C     = 10'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [8:0] BY_C     = 9'((SCREEN_H - BALL_SIZE) / 2);

    logic             w_tick;
    logic [9:0]       r_pad_l, r_pad_r, w_pad_l_n, w_pad_r_n;
    logic [9:0]       r_bx, w_bx_n;
    logic [8:0]       r_by, w_by_n;
    logic             r_vx, w_vx_n, r_vy, w_vy_n;
    logic [SPD_W-1:0] r_spd, w_spd_n, w_spd_mv;
    logic [3:0]       r_sl, w_sl_n, r_sr, w_sr_n;
    state_t           r_state, w_state_n;
    logic             r_win, w_win_n;
    logic [SRV_W-1:0] r_srv, w_srv_n;

    logic signed [10:0] w_x, w_y, w_pl, w_pr, w_sp, w_x_mv, w_y_mv;
    logic               w_vx_mv, w_vy_mv, w_ov_l, w_ov_r, w_pt_l, w_pt_r;

    function automatic logic [9:0] pad_next(input logic [9:0] pad, input logic [1:0] keys);
        logic signed [10:0] p;
        p = signed'({1'b0, pad});
        if (keys == KEY_UP) begin
            p = p - C_STEP;
            if (p < 11'sd0) p = 11'sd0;
        end else if (keys == KEY_DOWN) begin
            p = p + C_STEP;
            if (p > C_PAD_MAX) p = C_PAD_MAX;
        end
        return 10'(p);
    endfunction

    function automatic logic [SPD_W-1:0] spd_up(input logic [SPD_W-1:0] s);
        return (s == SPD_W'(SPEED_MAX)) ? s : s + SPD_W'(1);
    endfunction

    pong_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .i_clk  (clk),
        .i_rst  (rst),
        .o_tick (w_tick)
    );

    // Candidate ball motion for a PLAY tick; collisions use the pre-update paddles.
    always_comb begin
        w_x      = signed'({1'b0, r_bx});
        w_y      = signed'({2'b00, r_by});
        w_pl     = signed'({1'b0, r_pad_l});
        w_pr     = signed'({1'b0, r_pad_r});
        w_sp     = signed'(11'(r_spd));
        w_ov_l   = (w_y + C_BALL > w_pl) && (w_y < w_pl + C_PAD_H);
        w_ov_r   = (w_y + C_BALL > w_pr) && (w_y < w_pr + C_PAD_H);
        w_x_mv   = (r_vx == DIR_RIGHT) ? w_x + w_sp : w_x - w_sp;
        w_vx_mv  = r_vx;
        w_spd_mv = r_spd;
        w_pt_l   = 1'b0;
        w_pt_r   = 1'b0;
        if (r_vx == DIR_LEFT) begin
            if (w_x_mv <= C_LF) begin
                if (w_ov_l) begin
                    w_x_mv   = C_LF;
                    w_vx_mv  = DIR_RIGHT;
                    w_spd_mv = spd_up(r_spd);
                end else if (w_x_mv < 11'sd0) begin
                    w_pt_r = 1'b1;
                end
            end
        end else begin
            if (w_x_mv >= C_RF) begin
                if (w_ov_r) begin
                    w_x_mv   = C_RF;
                    w_vx_mv  = DIR_LEFT;
                    w_spd_mv = spd_up(r_spd);
                end else if (w_x_mv >= C_BX_MAX) begin
                    w_pt_l = 1'b1;
                end
            end
        end
        w_y_mv  = (r_vy == DIR_DOWN) ? w_y + 11'sd1 : w_y - 11'sd1;
        w_vy_mv = r_vy;
        if (w_y_mv >= C_BY_MAX) begin
            w_y_mv  = C_BY_MAX;
            w_vy_mv = DIR_UP;
        end else if (w_y_mv <= 11'sd0) begin
            w_y_mv  = 11'sd0;
            w_vy_mv = DIR_DOWN;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_srv_n   = r_srv;
        w_pad_l_n = r_pad_l;
        w_pad_r_n = r_pad_r;
        w_bx_n    = r_bx;
        w_by_n    = r_by;
        w_vx_n    = r_vx;
        w_vy_n    = r_vy;
        w_spd_n   = r_spd;
        w_sl_n    = r_sl;
        w_sr_n    = r_sr;
        w_win_n   = r_win;
        if (w_tick) begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_state_n = ST_SERVE;
                        w_srv_n   = '0;
                    end
                end
                ST_SERVE: begin
                    w_pad_l_n = pad_next(r_pad_l, keys_left);
                    w_pad_r_n = pad_next(r_pad_r, keys_right);
                    if (r_srv == SRV_W'(SERVE_DELAY - 1)) begin
                        w_state_n = ST_PLAY;
                        w_srv_n   = '0;
                    end else begin
                        w_srv_n = r_srv + SRV_W'(1);
                    end
                end
                ST_PLAY: begin
                    w_pad_l_n = pad_next(r_pad_l, keys_left);
                    w_pad_r_n = pad_next(r_pad_r, keys_right);
                    if (w_pt_l || w_pt_r) begin
                        if (w_pt_r) w_sr_n = r_sr + 4'd1;
                        else        w_sl_n = r_sl + 4'd1;
                        if ((w_pt_r ? r_sr : r_sl) + 4'd1 == 4'(MAX_SCORE)) begin
                            w_state_n = ST_OVER;
                            w_win_n   = w_pt_r;
                        end else begin
                            // Next serve heads toward whoever conceded.
                            w_state_n = ST_SERVE;
                            w_srv_n   = '0;
                            w_bx_n    = BX_C;
                            w_by_n    = BY_C;
                            w_spd_n   = SPD_W'(1);
                            w_vx_n    = w_pt_r ? DIR_LEFT : DIR_RIGHT;
                        end
                    end else begin
                        w_bx_n  = 10'(w_x_mv);
                        w_by_n  = 9'(w_y_mv);
                        w_vx_n  = w_vx_mv;
                        w_vy_n  = w_vy_mv;
                        w_spd_n = w_spd_mv;
                    end
                end
                ST_OVER: begin
                    if (start) begin
                        w_state_n = ST_SERVE;
                        w_srv_n   = '0;
                        w_sl_n    = 4'd0;
                        w_sr_n    = 4'd0;
                        w_win_n   = 1'b0;
                        w_bx_n    = BX_C;
                        w_by_n    = BY_C;
                        w_spd_n   = SPD_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_srv   <= '0;
            r_pad_l <= PAD_INIT;
            r_pad_r <= PAD_INIT;
            r_bx    <= BX_C;
            r_by    <= BY_C;
            r_vx    <= DIR_RIGHT;
            r_vy    <= DIR_DOWN;
            r_spd   <= SPD_W'(1);
            r_sl    <= 4'd0;
            r_sr    <= 4'd0;
            r_win   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_srv   <= w_srv_n;
            r_pad_l <= w_pad_l_n;
            r_pad_r <= w_pad_r_n;
            r_bx    <= w_bx_n;
            r_by    <= w_by_n;
            r_vx    <= w_vx_n;
            r_vy    <= w_vy_n;
            r_spd   <= w_spd_n;
            r_sl    <= w_sl_n;
            r_sr    <= w_sr_n;
            r_win   <= w_win_n;
        end
    end

    assign pad_left    = r_pad_l;
    assign pad_right   = r_pad_r;
    assign ball_x      = r_bx;
    assign ball_y      = r_by;
    assign score_left  = r_sl;
    assign score_right = r_sr;
    assign state       = r_state;
    assign winner      = r_win;
    assign frame_tick  = w_tick;

endmodule

// File: doc/pong_engine.md
Name: pong_engine

Overview:
Parametrised second-generation Pong game core. Owns paddle positions, ball position and velocity, paddle/wall collision, scoring and match sequencing.
Runs entirely on the system clock with an internal game-tick enable; there is no derived clock.
Feeds the video renderer (positions, scores) and the HUD (state, winner).

Parameters:
SCREEN_W, 640, playfield width in pixels
SCREEN_H, 480, playfield height in pixels
PAD_H, 64, paddle height
PAD_W, 8, paddle width
PAD_DIST, 16, gap between screen edge and paddle
BALL_SIZE, 8, ball edge length (square ball)
TICK_DIV, 18, game tick every 2^TICK_DIV clocks
PAD_STEP, 2, paddle pixels moved per tick
SPEED_MAX, 3, maximum horizontal ball speed in pixels per tick
SERVE_DELAY, 60, ticks the ball is held at centre before play resumes
MAX_SCORE, 9, score that ends the match

Ports:
clk in 1 system clock
rst in 1 synchronous active-high reset
keys_left in 2 left paddle keys: 10=up, 01=down, 00/11=hold
keys_right in 2 right paddle keys, same encoding
start in 1 level; starts a match from IDLE or OVER
pad_left out 10 top y of left paddle
pad_right out 10 top y of right paddle
ball_x out 10 top-left x of ball
ball_y out 9 top-left y of ball
score_left out 4 left player score
score_right out 4 right player score
state out 2 0=IDLE, 1=SERVE, 2=PLAY, 3=OVER
winner out 1 0=left, 1=right; valid only in OVER
frame_tick out 1 one-clk game-tick pulse

Behaviour:
- Reset (rst high at a clk edge) takes effect at that edge: tick counter=0; pads=(SCREEN_H-PAD_H)/2; ball=((SCREEN_W-BALL_SIZE)/2, (SCREEN_H-BALL_SIZE)/2); scores=0; state=IDLE; winner=0; vx=right; speed=1; vy=down; serve counter=0. Reset mid-game behaves identically.
- Tick: a TICK_DIV-bit counter free-runs. frame_tick=1 for the single clk in which the counter is all-ones. All game updates happen only on clocks where frame_tick=1.
- IDLE: nothing moves. start=1 on a tick -> SERVE.
- SERVE: ball held at centre. Paddles move. After SERVE_DELAY ticks -> PLAY.
- PLAY: paddles and ball move every tick. start is ignored.
- OVER: nothing moves. start=1 on a tick -> scores=0, winner=0, ball centred, speed=1 -> SERVE.
- Paddles (SERVE and PLAY only):
  - up: pad -= PAD_STEP, saturating at 0.
  - down: pad += PAD_STEP, saturating at SCREEN_H-PAD_H.
  - 00/11: no change.
- Ball arithmetic: done in 11 bits, no wrap. Horizontal step = speed (1..SPEED_MAX); vertical step = 1.
- Collision and overlap tests use pad values registered before the current tick's paddle update.
- Left face LF=PAD_DIST+PAD_W. Ball moving left with x-speed<=LF, overlap = (ball_y+BALL_SIZE>pad_left && ball_y<pad_left+PAD_H):
  - overlap: x=LF, vx flips to right, speed=min(speed+1, SPEED_MAX).
  - no overlap: ball keeps moving.
  - miss: x<speed -> score_right+1.
- Right face RF=SCREEN_W-PAD_DIST-PAD_W-BALL_SIZE: mirror of the left rule. Miss when x+speed>=SCREEN_W-BALL_SIZE -> score_left+1.
- Vertical walls: y clamps to 0 or SCREEN_H-BALL_SIZE and vy flips.
- A horizontal and a vertical bounce in the same tick are both applied.
- On a point:
  - If the new score==MAX_SCORE: state=OVER, winner=scorer.
  - Otherwise: state=SERVE, ball centred, speed=1, vx points toward the player who conceded, vy unchanged.
- Scores never exceed MAX_SCORE.

Decomposition:
- pong_pkg holds:
  - state encoding (IDLE/SERVE/PLAY/OVER)
  - key codes (KEY_UP=2'b10, KEY_DOWN=2'b01)
  - direction constants
  - default geometry constants
- Sub-module pong_tick_gen: the TICK_DIV counter and frame_tick output, with synchronous reset.
- Paddle, ball and FSM logic stay in pong_engine.

Test Plan:
- Use TICK_DIV=2 for simulation; all other parameters at defaults.
1. Reset -> pads=208/208, ball=(316,236), scores 0/0, state=0, frame_tick pulses every 4 clks.
2. start=1 -> SERVE. After 60 ticks -> PLAY. First PLAY tick: ball_x=317, ball_y=237.
3. Hold keys_left=10 -> pad_left 208,206,…,0, then stays 0. Hold 01 -> saturates at 416. keys=11 -> no change.
4. Ball moving left at x=26, speed 2, pad_left=ball_y-10 -> next tick x=24, vx=right, speed=3. Next hit leaves speed at 3.
5. Same approach with pad_left=0 and ball_y=300 -> ball passes face; once x<speed: score_right=1, state=SERVE, ball=(316,236), speed=1, vx=left.
6. score_right=8, left miss -> score_right=9, state=OVER, winner=1. start -> scores 0/0, state=SERVE. Asserting rst mid-PLAY restores all reset values at the next edge.
